// File: rtl/mfcc_mel_filter.sv
// Mel filterbank accumulator: each power bin is split between two adjacent
// triangular filters using a per-bin ROM weight/index, then the frame is dumped.
module mfcc_mel_filter #(
    parameter int unsigned N_BIN  = 256,
    parameter int unsigned N_FILT = 26,
    parameter int unsigned SPEC_W = 32,
    parameter int unsigned ACC_W  = 48
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spec_valid,
    input  logic [SPEC_W-1:0] spec_data,
    input  logic              spec_last,
    output logic              spec_ready,
    output logic [8:0]        rom_addr,
    input  logic [7:0]        rom_rd_data,
    output logic              mel_valid,
    output logic [ACC_W-1:0]  mel_data,
    output logic [4:0]        mel_idx,
    output logic              mel_last,
    input  logic              mel_ready,
    output logic              frame_err
);
    localparam int unsigned BIN_W = 8;
    localparam int unsigned K_W   = 5;
    localparam int unsigned PHI_W = SPEC_W + 8;
    localparam int unsigned PLO_W = SPEC_W + 9;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(N_BIN - 1);
    localparam logic [K_W-1:0]   LAST_K   = K_W'(N_FILT - 1);

    typedef enum logic [2:0] {S_IDLE, S_RD_W, S_RD_I, S_ACC, S_DUMP} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [BIN_W-1:0]   r_bin;
    logic [K_W-1:0]     r_k;
    logic [SPEC_W-1:0]  r_p;
    logic [7:0]         r_w;
    logic               r_last;
    logic [ACC_W-1:0]   r_acc [N_FILT];

    logic               w_bin_is_last;
    logic               w_frame_end;
    logic               w_dump_done;
    logic [7:0]         w_f;
    logic [PHI_W-1:0]   w_prod_hi;
    logic [PLO_W-1:0]   w_prod_lo;

    assign w_f           = rom_rd_data;
    assign w_bin_is_last = (r_bin == LAST_BIN);
    assign w_frame_end   = w_bin_is_last || r_last;
    assign w_dump_done   = (r_state == S_DUMP) && mel_ready && (r_k == LAST_K);
    // Upper filter gets p*w, lower neighbour gets p*(256-w)
    assign w_prod_hi     = PHI_W'(r_p) * PHI_W'(r_w);
    assign w_prod_lo     = PLO_W'(r_p) * PLO_W'(9'd256 - {1'b0, r_w});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        spec_ready = 1'b0;
        mel_valid  = 1'b0;
        mel_last   = 1'b0;
        mel_idx    = '0;
        mel_data   = '0;
        rom_addr   = '0;
        frame_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                spec_ready = 1'b1;
                if (spec_valid) w_next = S_RD_W;
            end
            S_RD_W: begin
                rom_addr = {1'b0, r_bin};
                w_next   = S_RD_I;
            end
            S_RD_I: begin
                rom_addr = {1'b1, r_bin};
                w_next   = S_ACC;
            end
            S_ACC: begin
                rom_addr  = {1'b1, r_bin};
                frame_err = (r_last != w_bin_is_last);
                w_next    = w_frame_end ? S_DUMP : S_IDLE;
            end
            S_DUMP: begin
                mel_valid = 1'b1;
                mel_idx   = r_k;
                mel_data  = r_acc[r_k];
                mel_last  = (r_k == LAST_K);
                if (w_dump_done) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bin  <= '0;
            r_k    <= '0;
            r_p    <= '0;
            r_w    <= '0;
            r_last <= 1'b0;
            for (int unsigned i = 0; i < N_FILT; i++) r_acc[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (spec_valid) begin
                        r_p    <= spec_data;
                        r_last <= spec_last;
                    end
                end
                S_RD_I: r_w <= rom_rd_data;
                S_ACC: begin
                    for (int unsigned i = 0; i < N_FILT; i++) begin
                        r_acc[i] <= r_acc[i]
                                  + ((w_f == 8'(i))     ? ACC_W'(w_prod_hi) : '0)
                                  + ((w_f == 8'(i + 1)) ? ACC_W'(w_prod_lo) : '0);
                    end
                    if (!w_frame_end) r_bin <= r_bin + 1'b1;
                end
                S_DUMP: begin
                    if (w_dump_done) begin
                        r_k   <= '0;
                        r_bin <= '0;
                        for (int unsigned i = 0; i < N_FILT; i++) r_acc[i] <= '0;
                    end else if (mel_ready) begin
                        r_k <= r_k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mfcc_mel_filter.sv
// Bench for mfcc_mel_filter: ROM model, arithmetic reference of the filterbank,
// and scenario tasks for reset, edge indices, throughput, backpressure and framing.
module tb_mfcc_mel_filter;
    localparam int unsigned N_BIN  = 256;
    localparam int unsigned N_FILT = 26;
    localparam int unsigned SPEC_W = 32;
    localparam int unsigned ACC_W  = 48;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              spec_valid = 1'b0;
    logic [SPEC_W-1:0] spec_data = '0;
    logic              spec_last = 1'b0;
    logic              spec_ready;
    logic [8:0]        rom_addr;
    logic [7:0]        rom_rd_data;
    logic              mel_valid;
    logic [ACC_W-1:0]  mel_data;
    logic [4:0]        mel_idx;
    logic              mel_last;
    logic              mel_ready = 1'b1;
    logic              frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int err_pulses = 0;

    logic [7:0]        rom [512];
    logic [SPEC_W-1:0] p_arr [N_BIN];
    logic [63:0]       exp_acc [32];
    logic [ACC_W-1:0]  got_data [32];

    mfcc_mel_filter #(.N_BIN(N_BIN), .N_FILT(N_FILT), .SPEC_W(SPEC_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .spec_valid(spec_valid), .spec_data(spec_data), .spec_last(spec_last), .spec_ready(spec_ready),
        .rom_addr(rom_addr), .rom_rd_data(rom_rd_data),
        .mel_valid(mel_valid), .mel_data(mel_data), .mel_idx(mel_idx), .mel_last(mel_last),
        .mel_ready(mel_ready), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Synchronous ROM with one cycle of read latency
    always @(posedge clk) rom_rd_data <= rom[rom_addr];

    always @(negedge clk) if (rst_n === 1'b1 && frame_err === 1'b1) err_pulses++;

    task automatic fill_rom_random();
        for (int b = 0; b < 256; b++) begin
            rom[b]       = 8'($urandom_range(0, 255));
            rom[256 + b] = 8'($urandom_range(0, 31));
        end
    endtask

    task automatic fill_p(input int mode);
        for (int b = 0; b < N_BIN; b++) p_arr[b] = (mode == 0) ? '0 : (mode == 1) ? 32'd1 : $urandom;
    endtask

    // Reference: each bin splits its power between filters f and f-1 by weight
    task automatic model(input int n);
        longint unsigned w, f;
        for (int i = 0; i < 32; i++) exp_acc[i] = '0;
        for (int b = 0; b < n; b++) begin
            w = longint'(rom[b]);
            f = longint'(rom[256 + b]);
            if (f < N_FILT) exp_acc[f] += longint'(p_arr[b]) * w;
            if (f >= 1 && f <= N_FILT) exp_acc[f - 1] += longint'(p_arr[b]) * (256 - w);
        end
    endtask

    task automatic send_frame(input int n, input int last_pos);
        int cnt;
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            spec_valid = 1'b1;
            spec_data  = p_arr[b];
            spec_last  = (b == last_pos);
            cnt = 0;
            while (spec_ready !== 1'b1 && cnt < 16) begin @(negedge clk); cnt++; end
            if (spec_ready !== 1'b1) begin
                n_checks++; n_fail++;
                $display("FAIL send_ready: bin %0d spec_ready=%b, required 1", b, spec_ready);
                spec_valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        spec_valid = 1'b0;
        spec_last  = 1'b0;
    endtask

    task automatic collect_dump(input int mode);
        int cyc, delivered, pat;
        logic stalled, pl, r;
        logic [ACC_W-1:0] pd;
        logic [4:0] pidx;
        cyc = 0; delivered = 0; pat = 0; stalled = 1'b0; pd = '0; pidx = '0; pl = 1'b0;
        while (mel_valid !== 1'b1 && cyc < 64) begin @(negedge clk); cyc++; end
        n_checks++;
        if (mel_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL dump_start: mel_valid=%b after %0d cycles, required 1", mel_valid, cyc);
            return;
        end
        cyc = 0;
        while (delivered < N_FILT && cyc < 512) begin
            n_checks++;
            if (mel_valid !== 1'b1 || spec_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL dump_hs: mel_valid=%b spec_ready=%b, required 1/0", mel_valid, spec_ready);
            end
            n_checks++;
            if (mel_idx !== 5'(delivered)) begin
                n_fail++;
                $display("FAIL dump_idx: got %0d, required %0d", mel_idx, delivered);
            end
            n_checks++;
            if (mel_data !== exp_acc[delivered][ACC_W-1:0]) begin
                n_fail++;
                $display("FAIL dump_data[%0d]: got %0d, required %0d", delivered, mel_data, exp_acc[delivered][ACC_W-1:0]);
            end
            n_checks++;
            if (mel_last !== (delivered == N_FILT - 1)) begin
                n_fail++;
                $display("FAIL dump_last[%0d]: got %b", delivered, mel_last);
            end
            if (stalled) begin
                n_checks++;
                if (mel_data !== pd || mel_idx !== pidx || mel_last !== pl) begin
                    n_fail++;
                    $display("FAIL dump_stable: got idx %0d data %0d, required idx %0d data %0d", mel_idx, mel_data, pidx, pd);
                end
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (pat % 4 == 0) || (pat % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            pat++;
            mel_ready = r;
            got_data[delivered] = mel_data;
            if (r) begin
                delivered++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1; pd = mel_data; pidx = mel_idx; pl = mel_last;
            end
            @(negedge clk);
            cyc++;
        end
        mel_ready = 1'b1;
        n_checks++;
        if (delivered != N_FILT) begin
            n_fail++;
            $display("FAIL dump_count: got %0d words, required %0d", delivered, N_FILT);
        end
        n_checks++;
        if (mel_valid !== 1'b0 || spec_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL dump_exit: mel_valid=%b spec_ready=%b, required 0/1", mel_valid, spec_ready);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_checks++;
        if (spec_ready !== 1'b1 || mel_valid !== 1'b0 || mel_data !== '0 || mel_idx !== '0 ||
            mel_last !== 1'b0 || frame_err !== 1'b0 || rom_addr !== '0) begin
            n_fail++;
            $display("FAIL %s: ready=%b mv=%b md=%0d mi=%0d ml=%b fe=%b ra=%0d, required 1 0 0 0 0 0 0",
                     tag, spec_ready, mel_valid, mel_data, mel_idx, mel_last, frame_err, rom_addr);
        end
    endtask

    task automatic test_reset();
        #1;
        check_idle_outputs("reset_state");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_single_bin();
        fill_rom_random();
        fill_p(0);
        p_arr[3] = 32'd100; rom[3] = 8'd64; rom[256 + 3] = 8'd5;
        model(N_BIN);
        send_frame(N_BIN, N_BIN - 1);
        collect_dump(0);
        n_checks++;
        if (got_data[5] !== 48'd6400 || got_data[4] !== 48'd19200) begin
            n_fail++;
            $display("FAIL single_bin: acc5=%0d acc4=%0d, required 6400 19200", got_data[5], got_data[4]);
        end
    endtask

    task automatic test_edge_idx();
        fill_rom_random();
        fill_p(0);
        p_arr[0] = 32'd2;  rom[0] = 8'd128; rom[256 + 0] = 8'd0;
        p_arr[1] = 32'd10; rom[1] = 8'd200; rom[256 + 1] = 8'(N_FILT);
        p_arr[2] = $urandom; rom[2] = 8'($urandom_range(0, 255)); rom[256 + 2] = 8'd31;
        model(N_BIN);
        send_frame(N_BIN, N_BIN - 1);
        collect_dump(2);
        n_checks++;
        if (got_data[0] !== 48'd256 || got_data[N_FILT - 1] !== 48'd560) begin
            n_fail++;
            $display("FAIL edge_idx: acc0=%0d acc25=%0d, required 256 560", got_data[0], got_data[N_FILT - 1]);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 2; t++) begin
            fill_rom_random();
            fill_p(2);
            model(N_BIN);
            send_frame(N_BIN, N_BIN - 1);
            collect_dump(2);
        end
    endtask

    task automatic test_throughput();
        int cnt;
        fill_rom_random();
        fill_p(2);
        model(N_BIN);
        @(negedge clk);
        spec_valid = 1'b1; spec_data = p_arr[0]; spec_last = 1'b0;
        cnt = 0;
        while (spec_ready !== 1'b1 && cnt < 16) begin @(negedge clk); cnt++; end
        for (int n = 0; n < 1024; n++) begin
            if (n % 4 == 0) begin
                spec_data = p_arr[n / 4];
                spec_last = (n / 4 == N_BIN - 1);
            end
            n_checks++;
            if (spec_ready !== (n % 4 == 0) || mel_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL throughput: cycle %0d spec_ready=%b mel_valid=%b", n, spec_ready, mel_valid);
            end
            @(negedge clk);
        end
        n_checks++;
        if (mel_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL dump_timing: mel_valid=%b at cycle 1024, required 1", mel_valid);
        end
        spec_valid = 1'b0;
        spec_last  = 1'b0;
        collect_dump(0);
    endtask

    task automatic test_back_to_back();
        fill_rom_random();
        fill_p(2);
        model(N_BIN);
        send_frame(N_BIN, N_BIN - 1);
        collect_dump(1);
    endtask

    task automatic test_frame_err();
        int e0;
        fill_rom_random();
        fill_p(2);
        e0 = err_pulses;
        model(100);
        send_frame(100, 99);
        collect_dump(2);
        n_checks++;
        if (err_pulses - e0 !== 1) begin
            n_fail++;
            $display("FAIL early_last_err: got %0d pulses, required 1", err_pulses - e0);
        end
        fill_p(2);
        e0 = err_pulses;
        model(N_BIN);
        send_frame(N_BIN, N_BIN - 1);
        collect_dump(0);
        n_checks++;
        if (err_pulses - e0 !== 0) begin
            n_fail++;
            $display("FAIL normal_frame_err: got %0d pulses, required 0", err_pulses - e0);
        end
        fill_p(2);
        e0 = err_pulses;
        model(N_BIN);
        send_frame(N_BIN, -1);
        collect_dump(0);
        n_checks++;
        if (err_pulses - e0 !== 1) begin
            n_fail++;
            $display("FAIL missing_last_err: got %0d pulses, required 1", err_pulses - e0);
        end
    endtask

    task automatic test_reset_mid();
        fill_rom_random();
        fill_p(2);
        send_frame(121, -1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_mid_frame");
        @(negedge clk);
        rst_n = 1'b1;
        fill_p(1);
        model(N_BIN);
        send_frame(N_BIN, N_BIN - 1);
        collect_dump(2);
    endtask

    initial begin
        test_reset();
        test_single_bin();
        test_edge_idx();
        test_random();
        test_throughput();
        test_back_to_back();
        test_frame_err();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mfcc_mel_filter.md
MFCC_MEL_FILTER -- requirements
Module: mfcc_mel_filter

Interface
REQ-001 Parameters SHALL be: N_BIN, 256, power-spectrum bins per frame (max 256); N_FILT, 26, mel filters per frame (2..31); SPEC_W, 32, power sample width; ACC_W, 48, accumulator/output width (SPEC_W+16).
REQ-002 Ports SHALL be (clock and reset first): clk in 1 system clock; rst_n in 1 asynchronous active-low reset; spec_valid in 1 bin sample valid; spec_data in SPEC_W unsigned power value; spec_last in 1 last bin of frame; spec_ready out 1 block can accept a bin; rom_addr out 9 melbank ROM address; rom_rd_data in 8 melbank ROM data; mel_valid out 1 filter energy valid; mel_data out ACC_W filter energy; mel_idx out 5 filter number; mel_last out 1 last filter of frame; mel_ready in 1 downstream accepts energy; frame_err out 1 one-cycle spec_last/bin-count mismatch pulse.
REQ-003 Clocking and reset SHALL be: one clock, clk; reset rst_n, asynchronous assert, active-low.

Function
REQ-004 ROM layout SHALL be: addr {0,b} = weight w(b), unsigned Q0.8; addr {1,b} = filter index f(b); b = bin number 0..N_BIN-1.
REQ-005 ROM read latency SHALL be 1 cycle: rom_rd_data is valid the cycle after rom_addr is presented.
REQ-006 FSM states SHALL be IDLE, RD_W, RD_I, ACC, DUMP.
REQ-007 spec_ready SHALL be 1 only in IDLE; a bin is accepted on spec_valid&&spec_ready; spec_data is latched to p; state goes to RD_W.
REQ-008 rom_addr SHALL be combinational from state: RD_W -> {0,bin}; RD_I and ACC -> {1,bin}; all other states -> 0.
REQ-009 In RD_I, rom_rd_data SHALL be latched as w; in ACC, rom_rd_data is used directly as f.
REQ-010 In ACC, if f<N_FILT: acc[f] += p*w; if 1<=f<=N_FILT: acc[f-1] += p*(256-w); any other f contributes nothing and is not flagged.
REQ-011 Throughput SHALL be exactly one bin per 4 cycles (IDLE,RD_W,RD_I,ACC).
REQ-012 Arithmetic SHALL be unsigned, full precision, 9-bit (256-w) multiplier; ACC_W=SPEC_W+16 cannot overflow, so no saturation.
REQ-013 Frame end SHALL occur at the ACC of bin N_BIN-1, or of any bin accepted with spec_last=1, whichever comes first; ACC then goes to DUMP, otherwise to IDLE with bin+1.
REQ-014 frame_err SHALL pulse for 1 cycle in that ACC when spec_last=1 with bin!=N_BIN-1, or bin==N_BIN-1 with spec_last=0; the frame is still dumped normally.
REQ-015 In DUMP: mel_valid=1, mel_idx=k, mel_data=acc[k], mel_last=(k==N_FILT-1); k increments on mel_valid&&mel_ready.
REQ-016 Output SHALL be held stable while mel_ready=0.
REQ-017 On the final dump handshake, all acc, bin and k SHALL clear to 0 and the state goes to IDLE; spec_ready rises the next cycle.
REQ-018 No bin SHALL be accepted during DUMP.

Reset
REQ-019 While rst_n=0, all of the following SHALL be cleared regardless of clk: state=IDLE; bin, k, p, w, all acc = 0; mel_valid, mel_data, mel_idx, mel_last, frame_err, rom_addr = 0; spec_ready=1.
REQ-020 Reset asserted mid-frame or mid-dump SHALL abandon the partial frame; the first bin after reset is bin 0.

Verification
REQ-021 Single-bin weight: N_BIN=256, only bin 3 p=100 with w(3)=64, f(3)=5, all other p=0 -> acc[5]=6400, acc[4]=19200; 26 dump words, others 0, mel_last on idx 25.
REQ-022 Edge indices: f=0 with w=128, p=2 -> only acc[0]+=256; f=N_FILT -> only acc[N_FILT-1]+=p*(256-w); f=31 -> nothing.
REQ-023 Throughput/ready: spec_valid held high for 256 bins -> spec_ready pattern 1,0,0,0 repeating; DUMP entered 1024 cycles after the first accept.
REQ-024 Backpressure: mel_ready toggled 1,0,0,1 during dump -> each of the 26 words delivered exactly once, stable while stalled, no accept until dump completes.
REQ-025 Early spec_last on bin 99 -> frame_err pulse, dump of partial sums, next frame starts at bin 0; missing spec_last at bin 255 -> frame_err pulse, normal dump.
REQ-026 rst_n low during bin 120 then released -> all outputs 0, spec_ready=1; a new full frame with p=1 everywhere yields the expected golden sums with no residue from the aborted frame.
